data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the mips_core data port. Accepts word address, byte-lane
//   write data and write enable from the core, and returns byte-lane read data with a
//   configurable read latency. Big-endian lane order: lane 0 = byte at addr+0 = MSB.
//   Zero-fills its array after reset and freezes writes once the core halts.
// PARAMETERS
//   ADDR_BITS  12  byte-address bits decoded; array holds 2**(ADDR_BITS-2) 32-bit words
//   READ_LAT   1   read latency in cycles, legal 0..3 (0 = combinational read)
// PORTS
//   clk            in   1       clock, all state on posedge
//   rst_b          in   1       asynchronous, active-low reset
//   mem_addr       in   32      byte address from core ALU result
//   mem_data_in    in   8x[0:3] write data lanes from core (lane 0 = MSB)
//   mem_write_en   in   1       write strobe from core, sampled on posedge
//   halted         in   1       core halt indication
//   mem_data_out   out  8x[0:3] read data lanes to core (lane 0 = MSB)
//   init_busy      out  1       high while zero-fill sequence runs
//   addr_err       out  1       sticky: misaligned access seen (mem_addr[1:0] != 0)
// BEHAVIOUR
//   Reset (rst_b=0, async): state<=INIT, fill counter<=0, all read pipeline stages<=0,
//     mem_data_out=0, init_busy=1, addr_err=0. Array contents are not reset directly.
//   States:
//     INIT  : one word per cycle, array[cnt]<=0, cnt++. Core writes ignored;
//             mem_data_out forced 0; addr_err not updated. After last word
//             (cnt==WORDS-1) -> RUN next cycle; init_busy drops with the RUN entry.
//     RUN   : normal service. halted==1 sampled on posedge -> HALTED.
//     HALT  : writes ignored; reads continue with same latency. Sticky until reset.
//   Addressing: word index = mem_addr[ADDR_BITS-1:2]; bits above ADDR_BITS-1 ignored
//     (address wraps modulo 2**ADDR_BITS). mem_addr[1:0] ignored for data; if nonzero
//     on a RUN cycle with mem_write_en=1, or on any RUN/HALT cycle, addr_err<=1 (sticky).
//   Write: in RUN, mem_write_en=1 at posedge -> array[idx] <= {lane0,lane1,lane2,lane3}.
//     Full-word writes only; no byte enables.
//   Read: word at idx is split into lanes, lane0=word[31:24] .. lane3=word[7:0].
//     READ_LAT=0: mem_data_out follows mem_addr combinationally (0 during INIT).
//     READ_LAT=N>=1: address sampled at edge k appears on mem_data_out after edge k+N-1
//       settles, i.e. valid for the whole cycle after N edges; pipeline shifts every cycle.
//   Read-during-write same word: read returns OLD contents (array sampled before update);
//     new data visible on the next read of that word.
//   halted and mem_write_en asserted the same edge in RUN: the write is performed, then
//     state -> HALTED (halt blocks writes from the following edge).
//   Reset mid-INIT or mid-RUN: immediate return to INIT, pipeline cleared, fill restarts
//     at word 0 (previously written data is lost after fill completes).
//   No handshake back to core: core must not issue accesses while init_busy=1; such
//     writes are silently dropped.
// TESTING
//   1 reset, run WORDS cycles: init_busy high exactly WORDS cycles; then read 0x0,0xFFC -> 0.
//   2 RUN, write 0x11223344 @0x010, read @0x010 (READ_LAT=1) -> lanes 11,22,33,44 next cycle.
//   3 write 0xAAAA5555 @0x020 then same edge read @0x020 -> old 0; following read -> AAAA5555.
//   4 assert halted, write 0xDEADBEEF @0x010 -> read @0x010 still 0x11223344; write on halt edge lands.
//   5 access @0x1013 with ADDR_BITS=12 -> hits word 0x010, addr_err=1 and stays 1.
//   6 pulse rst_b low mid-INIT and mid-RUN; sweep READ_LAT 0..3 -> latency = READ_LAT cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-port memory responder for mips_core: zero-fills after reset, serves
// full-word writes while running, freezes writes on halt, and returns
// big-endian byte lanes with a READ_LAT-cycle read pipeline (0..3).
module data_mem_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  input  logic            halted,
  output logic [0:3][7:0] mem_data_out,
  output logic            init_busy,
  output logic            addr_err
);

  localparam int unsigned IDX_W  = ADDR_BITS - 2;
  localparam int unsigned WORDS  = 1 << IDX_W;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               init_busy_q, init_busy_d;
  logic               addr_err_q, addr_err_d;

  logic [WORD_W-1:0]  mem_q [WORDS];

  logic               mem_we_c;
  logic [IDX_W-1:0]   mem_widx_c;
  logic [WORD_W-1:0]  mem_wdata_c;
  logic [IDX_W-1:0]   idx_c;
  logic [WORD_W-1:0]  rd_word_c;
  logic               addr_unused_c;

  // Word index decode; upper address bits wrap and are intentionally dropped
  assign idx_c         = mem_addr[ADDR_BITS-1:2];
  assign addr_unused_c = ^mem_addr[31:ADDR_BITS];

  // Array read before any same-edge update; reads are blanked while filling
  assign rd_word_c = (state_q == ST_INIT) ? '0 : mem_q[idx_c];

  // Next-state, fill counter, write port and sticky misalignment flag
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_err_d  = addr_err_q;
    mem_we_c    = 1'b0;
    mem_widx_c  = idx_c;
    mem_wdata_c = mem_data_in;

    case (state_q)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_widx_c  = cnt_q;
        mem_wdata_c = '0;
        cnt_d       = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we_c = mem_write_en;
        if (halted) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if ((state_q != ST_INIT) && (mem_addr[1:0] != 2'b00)) begin
      addr_err_d = 1'b1;
    end

    init_busy_d = (state_d == ST_INIT);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Storage array; contents are cleared by the fill sequence, not by reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_widx_c] <= mem_wdata_c;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb
      // Zero-latency read straight from the array
      assign mem_data_out = rd_word_c;
    end else begin : g_pipe
      logic [WORD_W-1:0] pipe_q [READ_LAT];
      logic [WORD_W-1:0] pipe_d [READ_LAT];

      // Read pipeline shifts every cycle
      always_comb begin
        pipe_d[0] = rd_word_c;
        for (int unsigned i = 1; i < READ_LAT; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // Pipeline registers, cleared on reset
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          for (int unsigned i = 0; i < READ_LAT; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign mem_data_out = pipe_q[READ_LAT-1];
    end
  endgenerate

  assign init_busy = init_busy_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one 12-bit/latency-1 instance plus four
// 6-bit instances at latency 0..3, all sharing stimulus, checked against a
// cycle-level behavioural model of memory contents, phase and read history.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int NDUT = 5;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en;
  logic            halted;
  logic [0:3][7:0] dout [NDUT];
  logic            busy [NDUT];
  logic            err  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned AB = (g == 0) ? 12 : 6;
    localparam int unsigned RL = (g == 0) ? 1 : g - 1;
    data_mem_responder #(.ADDR_BITS(AB), .READ_LAT(RL)) u_dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_write_en (mem_write_en),
      .halted       (halted),
      .mem_data_out (dout[g]),
      .init_busy    (busy[g]),
      .addr_err     (err[g])
    );
  end

  // Reference model: phase 0=filling, 1=running, 2=halted
  bit [31:0] mmem [NDUT][1024];
  int        ph   [NDUT];
  int        fill [NDUT];
  bit        merr [NDUT];
  bit [31:0] hist [NDUT][4];
  int        checks = 0;
  int        errors = 0;

  function automatic int words(int g);
    return (g == 0) ? 1024 : 16;
  endfunction

  function automatic int lat(int g);
    return (g == 0) ? 1 : g - 1;
  endfunction

  function automatic int widx(int g, logic [31:0] a);
    return int'(a[31:2]) & (words(g) - 1);
  endfunction

  task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NDUT; g++) begin
      ph[g]   = 0;
      fill[g] = words(g);
      merr[g] = 1'b0;
      for (int s = 0; s < 4; s++) hist[g][s] = '0;
      for (int w = 0; w < 1024; w++) mmem[g][w] = '0;
    end
  endtask

  task automatic check_all(string tag);
    bit [31:0] exp;
    for (int g = 0; g < NDUT; g++) begin
      if (lat(g) == 0) exp = (ph[g] == 0) ? 32'h0 : mmem[g][widx(g, mem_addr)];
      else             exp = hist[g][lat(g)-1];
      chk({tag, ".dout"}, g, dout[g], exp);
      chk({tag, ".busy"}, g, 32'(busy[g]), 32'(ph[g] == 0));
      chk({tag, ".err"},  g, 32'(err[g]), 32'(merr[g]));
    end
  endtask

  // Advance the model by one clock edge using the current inputs, then the DUTs
  task automatic step();
    int        idx;
    bit [31:0] r;
    for (int g = 0; g < NDUT; g++) begin
      idx = widx(g, mem_addr);
      r   = (ph[g] == 0) ? 32'h0 : mmem[g][idx];
      for (int s = 3; s > 0; s--) hist[g][s] = hist[g][s-1];
      hist[g][0] = r;
      if (ph[g] != 0 && mem_addr[1:0] != 2'b00) merr[g] = 1'b1;
      if (ph[g] == 0) begin
        fill[g]--;
        if (fill[g] == 0) ph[g] = 1;
      end else if (ph[g] == 1) begin
        if (mem_write_en) mmem[g][idx] = mem_data_in;
        if (halted) ph[g] = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(string tag);
    step();
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    rst_b = 1'b0;
    model_reset();
    #2;
    check_all(tag);
    #2;
    rst_b = 1'b1;
  endtask

  task automatic set_idle();
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    halted       = 1'b0;
  endtask

  // Aligned random access; main-instance word index kept at 32 and above
  task automatic drive_rand();
    logic [31:0] r;
    r            = $urandom();
    mem_addr     = {r[31:12], 10'($urandom_range(32, 1023)), 2'b00};
    mem_data_in  = $urandom();
    mem_write_en = 1'($urandom_range(0, 1));
  endtask

  task automatic run_fill(string tag, bit rnd);
    int n;
    n = 0;
    while (busy[0] === 1'b1 && n < 2000) begin
      if (rnd) drive_rand();
      cycle(tag);
      n++;
    end
    chk({tag, ".len"}, 0, 32'(n), 32'd1024);
  endtask

  initial begin
    int meas [NDUT];
    rst_b = 1'b0;
    set_idle();
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Reset partway through the fill, with writes attempted meanwhile
    for (int i = 0; i < 500; i++) begin
      drive_rand();
      cycle("init_a");
    end
    set_idle();
    do_reset("rst_mid_init");
    run_fill("fill1", 1'b1);

    set_idle();
    cycle("rd0");
    chk("rd_0x000", 0, dout[0], 32'h0);
    mem_addr = 32'hFFC;
    cycle("rdffc");
    chk("rd_0xffc", 0, dout[0], 32'h0);

    // Basic write/read and lane order
    mem_addr = 32'h10; mem_data_in = 32'h11223344; mem_write_en = 1'b1;
    cycle("t2_wr");
    mem_write_en = 1'b0;
    cycle("t2_rd");
    chk("t2_word", 0, dout[0], 32'h11223344);
    chk("t2_lane0", 0, 32'(dout[0][0]), 32'h11);
    chk("t2_lane3", 0, 32'(dout[0][3]), 32'h44);

    // Reset while running loses data once the fill completes
    do_reset("rst_mid_run");
    run_fill("fill2", 1'b0);
    mem_addr = 32'h10;
    cycle("lost");
    chk("lost_data", 0, dout[0], 32'h0);
    mem_data_in = 32'h11223344; mem_write_en = 1'b1;
    cycle("t2b_wr");
    mem_write_en = 1'b0;
    cycle("t2b_rd");
    chk("t2b_word", 0, dout[0], 32'h11223344);

    // Read-during-write returns old contents
    mem_addr = 32'h20; mem_data_in = 32'hAAAA5555; mem_write_en = 1'b1;
    cycle("t3_rdw");
    chk("t3_old", 0, dout[0], 32'h0);
    mem_write_en = 1'b0;
    cycle("t3_new");
    chk("t3_new", 0, dout[0], 32'hAAAA5555);

    // Latency probe: switch read address and count edges until new data shows
    mem_addr = 32'h40; mem_data_in = 32'hCAFEF00D; mem_write_en = 1'b1;
    cycle("lp_w0");
    mem_addr = 32'h44; mem_data_in = 32'h12345678;
    cycle("lp_w1");
    mem_write_en = 1'b0; mem_addr = 32'h40;
    for (int i = 0; i < 4; i++) cycle("lp_hold");
    mem_addr = 32'h44;
    #1;
    for (int g = 0; g < NDUT; g++) meas[g] = -1;
    for (int n = 0; n <= 4; n++) begin
      for (int g = 0; g < NDUT; g++)
        if (meas[g] < 0 && dout[g] === 32'h12345678) meas[g] = n;
      if (n < 4) cycle("lp_run");
    end
    for (int g = 0; g < NDUT; g++) chk("latency", g, 32'(meas[g]), 32'(lat(g)));

    // Randomized running traffic
    for (int i = 0; i < 300; i++) begin
      drive_rand();
      cycle("rand_run");
    end
    chk("err_clean", 0, 32'(err[0]), 32'h0);

    // Halt: write on the halt edge lands, later writes are dropped
    mem_addr = 32'h30; mem_data_in = 32'h0BADF00D; mem_write_en = 1'b1; halted = 1'b1;
    cycle("t4_halt_edge");
    halted = 1'b0;
    mem_addr = 32'h10; mem_data_in = 32'hDEADBEEF;
    cycle("t4_wr_halted");
    mem_write_en = 1'b0;
    cycle("t4_rd");
    chk("t4_keep", 0, dout[0], 32'h11223344);
    mem_addr = 32'h30;
    cycle("t4_rd_edge");
    chk("t4_edge_wr", 0, dout[0], 32'h0BADF00D);

    // Misaligned, out-of-range address wraps and sets the sticky error
    mem_addr = 32'h1013;
    cycle("t5");
    chk("t5_err", 0, 32'(err[0]), 32'h1);
    chk("t5_data", 0, dout[0], 32'h11223344);
    mem_addr = 32'h0;
    for (int i = 0; i < 3; i++) cycle("t5_hold");
    chk("t5_sticky", 0, 32'(err[0]), 32'h1);

    // Random traffic while halted
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      halted = 1'($urandom_range(0, 1));
      cycle("rand_halt");
    end

    // Reset out of the halted state
    set_idle();
    do_reset("rst_halt");
    for (int i = 0; i < 20; i++) cycle("post_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
